// File: rtl/instr_fetch.sv
// Instruction fetch engine: issues imem reads for pc_i, drives next_pc_o/stall_o, buffers {pc, instr, err} for decode.
// Latency: grant at t, rvalid at t+1, instr_valid_o at t+2 (zero-wait memory).
// Backpressure: imem_req_o drops once in-flight + pending-drop + buffered entries reach FIFO_DEPTH; a pop frees credit on the following cycle.
module instr_fetch #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        stall_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    input  logic        instr_ready_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [31:0]   pcq  [FIFO_DEPTH];
    entry_t        fifo [FIFO_DEPTH];
    entry_t        head;

    logic [CW+1:0] used;
    logic          accept;
    logic          rv_drop;
    logic          rv_live;
    logic          rv_any;
    logic          pop;

    // Credit counts every slot that a response may eventually occupy. With
    // FIFO_DEPTH=2 this sustains two fetches per three cycles; deeper buffers
    // reach one fetch per cycle.
    assign used        = {2'b00, outstanding} + {2'b00, drop} + {2'b00, fifo_count};
    assign imem_req_o  = !rst_i && !redirect_i && (used < (CW+2)'(FIFO_DEPTH));
    assign imem_addr_o = {pc_i[31:2], 2'b00};
    assign accept      = imem_req_o && imem_gnt_i;

    // Responses to wrong-path fetches are consumed first; only then does data reach the buffer.
    assign rv_drop = imem_rvalid_i && (drop != '0);
    assign rv_live = imem_rvalid_i && (drop == '0) && (outstanding != '0);
    assign rv_any  = rv_drop || rv_live;

    assign head          = fifo[fifo_rd];
    assign instr_valid_o = (fifo_count != '0) && !redirect_i;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign instr_err_o   = head.err;
    assign pop           = instr_valid_o && instr_ready_i;

    // PC handshake: a redirect wins, otherwise advance only on an accepted fetch.
    always_comb begin
        stall_o   = 1'b1;
        next_pc_o = pc_i;
        if (!rst_i) begin
            if (redirect_i) begin
                stall_o   = 1'b0;
                next_pc_o = redirect_pc_i;
            end else if (accept) begin
                stall_o   = 1'b0;
                next_pc_o = pc_i + 32'd4;
            end
        end
    end

    // Counters and pointers; a redirect converts everything in flight into responses to drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else if (redirect_i) begin
            outstanding <= '0;
            drop        <= outstanding + drop - CW'(rv_any);
            fifo_count  <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rv_live);
            drop        <= drop - CW'(rv_drop);
            fifo_count  <= fifo_count + CW'(rv_live) - CW'(pop);
            pcq_wr      <= pcq_wr + AW'(accept);
            pcq_rd      <= pcq_rd + AW'(rv_live);
            fifo_wr     <= fifo_wr + AW'(rv_live);
            fifo_rd     <= fifo_rd + AW'(pop);
        end
    end

    // Storage: in-flight PCs and returned instructions; cleared so the head reads as zero after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pcq[i]  <= '0;
                fifo[i] <= '0;
            end
        end else begin
            if (accept) begin
                pcq[pcq_wr] <= pc_i;
            end
            if (rv_live && !redirect_i) begin
                fifo[fifo_wr] <= '{pc: pcq[pcq_rd], instr: imem_rdata_i, err: imem_err_i};
            end
        end
    end

    // A response with nothing in flight and nothing to drop is a memory-side protocol error.
    rvalid_protocol: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (outstanding != '0 || drop != '0));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [31:0] next_pc_o;
    logic        stall_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;
    logic        instr_ready_i;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } ent_t;

    instr_fetch #(.FIFO_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .next_pc_o(next_pc_o), .stall_o(stall_o),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_err_o(instr_err_o), .instr_ready_i(instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; pc_i = '0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0; instr_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; pc_i = 32'h1234; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b1;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0; instr_ready_i = 1'b0;
        settle();
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", imem_req_o); end
        checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rst_stall got=%0b exp=1", stall_o); end
        checks++; if (next_pc_o !== 32'h1234) begin failures++; $display("FAIL rst_next_pc got=%h exp=00001234", next_pc_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0 || instr_pc_o !== 32'h0 || instr_err_o !== 1'b0) begin
            failures++; $display("FAIL rst_head got=%h/%h/%0b exp=0/0/0", instr_o, instr_pc_o, instr_err_o); end
        tick();
        rst_i = 1'b0; imem_gnt_i = 1'b1; pc_i = 32'h40;
        settle();
        checks++; if (imem_req_o !== 1'b1 || stall_o !== 1'b0 || next_pc_o !== 32'h44) begin
            failures++; $display("FAIL rst_first_fetch got req=%0b stall=%0b next=%h exp 1/0/00000044", imem_req_o, stall_o, next_pc_o); end
        tick();
        pc_i = 32'h44;
        tick();
        pc_i = 32'h48;
        settle();
        checks++; if (imem_req_o !== 1'b0 || stall_o !== 1'b1) begin
            failures++; $display("FAIL rst_two_inflight got req=%0b stall=%0b exp 0/1", imem_req_o, stall_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || stall_o !== 1'b1 || next_pc_o !== 32'h48) begin
            failures++; $display("FAIL rst_midfetch got req=%0b valid=%0b stall=%0b next=%h exp 0/0/1/00000048",
                                 imem_req_o, instr_valid_o, stall_o, next_pc_o); end
        tick();
        rst_i = 1'b0; imem_gnt_i = 1'b0;
        settle();
        checks++; if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin
            failures++; $display("FAIL rst_cleared got req=%0b valid=%0b exp 1/0", imem_req_o, instr_valid_o); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] pc_tab [6];
        logic        req_tab [6];
        logic        vld_tab [6];
        logic [31:0] ipc_tab [6];
        logic [31:0] exp_next;
        pc_tab  = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h10};
        req_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vld_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ipc_tab = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pc_i          = pc_tab[k];
            imem_rvalid_i = (k > 0) && req_tab[k-1];
            imem_rdata_i  = (k > 0) ? (32'hC0DE0000 | pc_tab[k-1]) : 32'h0;
            exp_next      = req_tab[k] ? pc_tab[k] + 32'd4 : pc_tab[k];
            settle();
            checks++; if (imem_req_o !== req_tab[k] || imem_addr_o !== pc_tab[k] || stall_o !== !req_tab[k] || next_pc_o !== exp_next) begin
                failures++; $display("FAIL stream_fetch c%0d got req=%0b addr=%h stall=%0b next=%h exp %0b/%h/%0b/%h",
                                     k, imem_req_o, imem_addr_o, stall_o, next_pc_o, req_tab[k], pc_tab[k], !req_tab[k], exp_next); end
            checks++; if (instr_valid_o !== vld_tab[k]) begin
                failures++; $display("FAIL stream_valid c%0d got=%0b exp=%0b", k, instr_valid_o, vld_tab[k]); end
            if (vld_tab[k]) begin
                checks++; if (instr_pc_o !== ipc_tab[k] || instr_o !== (32'hC0DE0000 | ipc_tab[k])) begin
                    failures++; $display("FAIL stream_instr c%0d got pc=%h instr=%h exp pc=%h", k, instr_pc_o, instr_o, ipc_tab[k]); end
            end
            tick();
        end
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
        pc_i = 32'h10; settle();
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL bp_grant0 got=%0b exp=1", imem_req_o); end
        tick();
        pc_i = 32'h14; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA0; settle();
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL bp_grant1 got=%0b exp=1", imem_req_o); end
        tick();
        pc_i = 32'h18; imem_rdata_i = 32'hA1; settle();
        checks++; if (imem_req_o !== 1'b0 || stall_o !== 1'b1) begin
            failures++; $display("FAIL bp_credit got req=%0b stall=%0b exp 0/1", imem_req_o, stall_o); end
        tick();
        imem_rvalid_i = 1'b0; settle();
        checks++; if (imem_req_o !== 1'b0 || stall_o !== 1'b1 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h10 || instr_o !== 32'hA0) begin
            failures++; $display("FAIL bp_full got req=%0b stall=%0b valid=%0b pc=%h instr=%h exp 0/1/1/00000010/000000a0",
                                 imem_req_o, stall_o, instr_valid_o, instr_pc_o, instr_o); end
        tick();
        instr_ready_i = 1'b1; settle();
        checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            failures++; $display("FAIL bp_pop_cycle got req=%0b valid=%0b exp 0/1", imem_req_o, instr_valid_o); end
        tick();
        instr_ready_i = 1'b0; imem_gnt_i = 1'b0; settle();
        checks++; if (imem_req_o !== 1'b1 || instr_pc_o !== 32'h14 || instr_o !== 32'hA1) begin
            failures++; $display("FAIL bp_after_pop got req=%0b pc=%h instr=%h exp 1/00000014/000000a1", imem_req_o, instr_pc_o, instr_o); end
        tick();
    endtask

    task automatic test_gnt_stall();
        do_reset();
        pc_i = 32'h100; imem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (stall_o !== 1'b1 || imem_addr_o !== 32'h100 || next_pc_o !== 32'h100 || imem_req_o !== 1'b1) begin
                failures++; $display("FAIL gnt_wait c%0d got stall=%0b addr=%h next=%h req=%0b exp 1/00000100/00000100/1",
                                     k, stall_o, imem_addr_o, next_pc_o, imem_req_o); end
            tick();
        end
        imem_gnt_i = 1'b1; settle();
        checks++; if (stall_o !== 1'b0 || next_pc_o !== 32'h104) begin
            failures++; $display("FAIL gnt_accept got stall=%0b next=%h exp 0/00000104", stall_o, next_pc_o); end
        tick();
        imem_gnt_i = 1'b0; pc_i = 32'h107; settle();
        checks++; if (imem_addr_o !== 32'h104) begin failures++; $display("FAIL addr_align got=%h exp=00000104", imem_addr_o); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
        pc_i = 32'h200; tick();
        pc_i = 32'h204; tick();
        pc_i = 32'h208; redirect_i = 1'b1; redirect_pc_i = 32'h80000000; settle();
        checks++; if (next_pc_o !== 32'h80000000 || stall_o !== 1'b0 || imem_req_o !== 1'b0) begin
            failures++; $display("FAIL redir_cycle got next=%h stall=%0b req=%0b exp 80000000/0/0", next_pc_o, stall_o, imem_req_o); end
        tick();
        redirect_i = 1'b0; pc_i = 32'h80000000; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD00200; settle();
        checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            failures++; $display("FAIL redir_drop1 got req=%0b valid=%0b exp 0/0", imem_req_o, instr_valid_o); end
        tick();
        imem_rdata_i = 32'hBAD00204; settle();
        checks++; if (imem_req_o !== 1'b1 || instr_valid_o !== 1'b0 || next_pc_o !== 32'h80000004) begin
            failures++; $display("FAIL redir_drop2 got req=%0b valid=%0b next=%h exp 1/0/80000004", imem_req_o, instr_valid_o, next_pc_o); end
        tick();
        pc_i = 32'h80000004; imem_gnt_i = 1'b0; imem_rdata_i = 32'h600D0000; settle();
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_no_stale got=%0b exp=0", instr_valid_o); end
        tick();
        imem_rvalid_i = 1'b0; settle();
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h80000000 || instr_o !== 32'h600D0000 || instr_err_o !== 1'b0) begin
            failures++; $display("FAIL redir_first got valid=%0b pc=%h instr=%h err=%0b exp 1/80000000/600d0000/0",
                                 instr_valid_o, instr_pc_o, instr_o, instr_err_o); end
        tick();
    endtask

    task automatic test_redirect_pop_wrap();
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
        pc_i = 32'h300; tick();
        pc_i = 32'h304; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h11; tick();
        pc_i = 32'h308; imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFFFFFC;
        imem_rdata_i = 32'h22; instr_ready_i = 1'b1; settle();
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_pop_valid got=%0b exp=0", instr_valid_o); end
        tick();
        redirect_i = 1'b0; imem_rvalid_i = 1'b0; pc_i = 32'hFFFFFFFC; imem_gnt_i = 1'b1; settle();
        checks++; if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || next_pc_o !== 32'h0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL wrap_accept got valid=%0b req=%0b next=%h stall=%0b exp 0/1/00000000/0",
                                 instr_valid_o, imem_req_o, next_pc_o, stall_o); end
        tick();
        pc_i = 32'h0; settle();
        checks++; if (imem_req_o !== 1'b1 || next_pc_o !== 32'h4) begin
            failures++; $display("FAIL drop_cleared got req=%0b next=%h exp 1/00000004", imem_req_o, next_pc_o); end
        tick();
        pc_i = 32'h4; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h33; imem_err_i = 1'b1; tick();
        imem_rdata_i = 32'h44; imem_err_i = 1'b0; settle();
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFFFFFC || instr_o !== 32'h33 || instr_err_o !== 1'b1) begin
            failures++; $display("FAIL err_entry got valid=%0b pc=%h instr=%h err=%0b exp 1/fffffffc/00000033/1",
                                 instr_valid_o, instr_pc_o, instr_o, instr_err_o); end
        tick();
        imem_rvalid_i = 1'b0; settle();
        checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'h44 || instr_err_o !== 1'b0) begin
            failures++; $display("FAIL after_err got valid=%0b pc=%h instr=%h err=%0b exp 1/00000000/00000044/0",
                                 instr_valid_o, instr_pc_o, instr_o, instr_err_o); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] m_infl [$];
        logic [31:0] mem_q [$];
        ent_t        m_fifo [$];
        int          m_drop;
        logic        prev_redir;
        logic        exp_req;
        logic        exp_valid;
        logic        exp_stall;
        logic [31:0] exp_next;
        ent_t        e;
        do_reset();
        m_drop = 0; prev_redir = 1'b0;
        pc_i = $urandom() & 32'hFFFFFFFC;
        for (int cyc = 0; cyc < 500; cyc++) begin
            redirect_i    = !prev_redir && ($urandom_range(0, 9) == 0);
            redirect_pc_i = $urandom() & 32'hFFFFFFFC;
            imem_gnt_i    = ($urandom_range(0, 3) != 0);
            instr_ready_i = ($urandom_range(0, 3) != 0);
            imem_rvalid_i = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
            imem_rdata_i  = $urandom();
            imem_err_i    = imem_rvalid_i && ($urandom_range(0, 7) == 0);
            exp_req   = !redirect_i && (m_infl.size() + m_drop + m_fifo.size() < 2);
            exp_valid = !redirect_i && (m_fifo.size() > 0);
            exp_stall = !redirect_i && !(exp_req && imem_gnt_i);
            exp_next  = redirect_i ? redirect_pc_i : (exp_stall ? pc_i : pc_i + 32'd4);
            settle();
            checks++; if (imem_req_o !== exp_req || imem_addr_o !== {pc_i[31:2], 2'b00}) begin
                failures++; $display("FAIL rnd_req c%0d got req=%0b addr=%h exp %0b/%h", cyc, imem_req_o, imem_addr_o, exp_req, pc_i); end
            checks++; if (stall_o !== exp_stall || next_pc_o !== exp_next) begin
                failures++; $display("FAIL rnd_pc c%0d got stall=%0b next=%h exp %0b/%h", cyc, stall_o, next_pc_o, exp_stall, exp_next); end
            checks++; if (instr_valid_o !== exp_valid) begin
                failures++; $display("FAIL rnd_valid c%0d got=%0b exp=%0b", cyc, instr_valid_o, exp_valid); end
            if (exp_valid) begin
                checks++; if (instr_pc_o !== m_fifo[0].pc || instr_o !== m_fifo[0].instr || instr_err_o !== m_fifo[0].err) begin
                    failures++; $display("FAIL rnd_instr c%0d got %h/%h/%0b exp %h/%h/%0b", cyc, instr_pc_o, instr_o, instr_err_o,
                                         m_fifo[0].pc, m_fifo[0].instr, m_fifo[0].err); end
            end
            // Reference update for the coming edge.
            if (redirect_i) begin
                m_drop = m_infl.size() + m_drop - (imem_rvalid_i ? 1 : 0);
                m_infl.delete();
                m_fifo.delete();
            end else begin
                if (exp_valid && instr_ready_i) void'(m_fifo.pop_front());
                if (imem_rvalid_i) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        e.pc = m_infl.pop_front(); e.instr = imem_rdata_i; e.err = imem_err_i;
                        m_fifo.push_back(e);
                    end
                end
                if (exp_req && imem_gnt_i) m_infl.push_back(pc_i);
            end
            if (imem_rvalid_i) void'(mem_q.pop_front());
            if (exp_req && imem_gnt_i) mem_q.push_back(pc_i);
            prev_redir = redirect_i;
            tick();
            if (!exp_stall) pc_i = exp_next;
        end
        redirect_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_pop_wrap();
        test_random();
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
